// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus transmit sequencer feeding uart_tx.
// Producers push bytes at up to one per clock. The sequencer pops one byte
// at a time into tx_data and handshakes with uart_tx over send/busy.
// Optional feature: define UART_TXQ_OVF_EN to add the ovf_count port, a
// saturating count of pushes dropped while the FIFO was full.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          tx_send,
  output logic [7:0]    tx_data,
  input  logic          tx_busy
`ifdef UART_TXQ_OVF_EN
  ,
  output logic [7:0]    ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          pop, push;

  // Status decodes come from registered count only.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop is the IDLE->SEND transition; a push may enter a full FIFO only
  // when a byte leaves in the same cycle.
  assign pop  = (state_q == S_IDLE) && !empty && !tx_busy;
  assign push = wr_en && (!full || pop);

  // State register.
  // NOTE: sequential state uses non-blocking assignments and the async
  // active-low reset in the sensitivity list, so every flop updates from
  // pre-edge values and clears immediately on rst_n falling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake output decode.
  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    tx_send = 1'b0;
    unique case (state_q)
      S_IDLE: if (pop) state_d = S_SEND;
      S_SEND: begin
        // Held until busy rises: uart_tx only samples send on a baud tick.
        tx_send = 1'b1;
        if (tx_busy) state_d = S_WAIT;
      end
      S_WAIT:  if (!tx_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pointers, occupancy and the byte presented to uart_tx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      tx_data <= 8'h00;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) begin
        rp      <= rp + AW'(1);
        tx_data <= mem[rp];
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; contents are only ever read behind the
  // pointers, so clearing it would add a reset net to every bit for nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_data;
  end

`ifdef UART_TXQ_OVF_EN
  // Saturating count of pushes dropped because the FIFO was full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 ovf_count <= 8'h00;
    else if (wr_en && !push && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a behavioural uart_tx busy model
// records every byte it accepts, and directed plus randomized pushes are
// compared against an expected-output queue built from accepted pushes.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full, empty;
  logic [CW-1:0] count;
  logic          tx_send;
  logic [7:0]    tx_data;
  logic          tx_busy;
`ifdef UART_TXQ_OVF_EN
  logic [7:0]    ovf_count;
`endif

  uart_tx_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .tx_send (tx_send),
    .tx_data (tx_data),
    .tx_busy (tx_busy)
`ifdef UART_TXQ_OVF_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  always #10 clk = ~clk;  // CLOCK_50

  int n_vec = 0;
  int n_err = 0;

  // ---------------- uart_tx behavioural model ----------------
  // Controlled by the main sequence.
  int   hold_len   = 1;  // cycles busy stays high per byte
  int   tick_delay = 0;  // cycles send must be seen before busy rises
  bit   stuck      = 0;  // freeze busy high once raised
  // Observed by the main sequence.
  logic [7:0] out_q[$];
  int   send_pulses = 0;
  int   stable_err  = 0;
  logic busy_m = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  int   hold = 0;
  int   wcnt = 0;
  logic prev_send = 1'b0;

  assign tx_busy = busy_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m = 1'b0; hold = 0; wcnt = 0; prev_send = 1'b0;
    end else begin
      #1;
      if (tx_send && !prev_send) send_pulses++;
      prev_send = tx_send;
      if (busy_m) begin
        if (tx_data !== cur_byte) stable_err++;
        if (!stuck) begin
          if (hold == 0) busy_m = 1'b0;
          else hold--;
        end
      end else if (tx_send) begin
        if (wcnt >= tick_delay) begin
          busy_m   = 1'b1;
          cur_byte = tx_data;
          out_q.push_back(tx_data);
          hold     = hold_len - 1;
          wcnt     = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // ---------------- reference expectations ----------------
  logic [7:0] exp_q[$];
  int out_base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (expect_accept) exp_q.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  // Wait for everything expected to have been captured, then compare order.
  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 5000; k++) begin
      if (out_q.size() - out_base >= exp_q.size() && !tx_busy && !tx_send && empty) break;
      step();
    end
    check({tag, "_timeout"}, 32'(k < 5000), 32'd1);
    check({tag, "_len"}, 32'(out_q.size() - out_base), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (out_base + i < out_q.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(out_q[out_base + i]), 32'(exp_q[i]));
    out_base = out_q.size();
    exp_q.delete();
  endtask

  initial begin
    int p0, pushed, k;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check("rst_full",    32'(full),    32'd0);
    check("rst_empty",   32'(empty),   32'd1);
    check("rst_count",   32'(count),   32'd0);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
`ifdef UART_TXQ_OVF_EN
    check("rst_ovf",     32'(ovf_count), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Single byte: send rises in the cycle after the second edge.
    hold_len = 4; tick_delay = 0;
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    step();
    wr_en = 1'b0;
    check("single_send_e0",  32'(tx_send), 32'd0);
    check("single_count_e0", 32'(count),   32'd1);
    check("single_empty_e0", 32'(empty),   32'd0);
    step();
    check("single_send_e1",  32'(tx_send), 32'd1);
    check("single_data_e1",  32'(tx_data), 32'hA5);
    check("single_count_e1", 32'(count),   32'd0);
    drain("single");

    // Burst with long busy windows.
    hold_len = 100; tick_delay = 2;
    p0 = send_pulses;
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      step();
    end
    wr_en = 1'b0;
    drain("burst");
    check("burst_pulses", 32'(send_pulses - p0), 32'd5);
    check("burst_stable", 32'(stable_err),       32'd0);

    // Fill with busy frozen after the first byte: 17 accepted, 18th dropped.
    hold_len = 3; tick_delay = 0; stuck = 1;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i); exp_q.push_back(8'h40 + 8'(i));
      step();
      if (i == 15) begin
        check("fill_count15", 32'(count), 32'd15);
        check("fill_full15",  32'(full),  32'd0);
      end
    end
    check("fill_count16", 32'(count),   32'd16);
    check("fill_full16",  32'(full),    32'd1);
    check("fill_held",    32'(tx_data), 32'h40);
    wr_data = 8'h99;  // dropped
    step();
    wr_en = 1'b0;
    check("ovf_drop_count", 32'(count), 32'd16);
`ifdef UART_TXQ_OVF_EN
    check("ovf_count1", 32'(ovf_count), 32'd1);
`endif

    // Release busy and time a push to coincide with the next pop.
    stuck = 0;
    for (k = 0; k < 50 && tx_busy; k++) step();
    check("release_timeout", 32'(k < 50), 32'd1);
    step();                       // WAIT -> IDLE edge
    wr_en = 1'b1; wr_data = 8'hEE; exp_q.push_back(8'hEE);
    step();                       // pop + push edge
    wr_en = 1'b0;
    check("pushpop_count", 32'(count),   32'd16);
    check("pushpop_full",  32'(full),    32'd1);
    check("pushpop_send",  32'(tx_send), 32'd1);
`ifdef UART_TXQ_OVF_EN
    check("pushpop_ovf",   32'(ovf_count), 32'd1);
`endif
    drain("full");

    // Randomized wrap-around: 40 bytes, never more outstanding than DEPTH.
    hold_len = int'($urandom_range(1, 4)); tick_delay = int'($urandom_range(0, 2));
    pushed = 0;
    for (int cyc = 0; cyc < 4000 && pushed < 40; cyc++) begin
      if (pushed - (out_q.size() - out_base) < DEPTH && $urandom_range(0, 3) != 0) begin
        wr_en = 1'b1; wr_data = 8'($urandom); exp_q.push_back(wr_data); pushed++;
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    wr_en = 1'b0;
    check("wrap_pushed", 32'(pushed), 32'd40);
    drain("wrap");

    // Reset in SEND with 3 bytes queued.
    hold_len = 2; tick_delay = 20;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    check("pre_rst_send",  32'(tx_send), 32'd1);
    check("pre_rst_count", 32'(count),   32'd3);
    p0 = send_pulses;
    rst_n = 1'b0;
    #1;
    check("arst_send",  32'(tx_send), 32'd0);
    check("arst_empty", 32'(empty),   32'd1);
    check("arst_count", 32'(count),   32'd0);
    check("arst_data",  32'(tx_data), 32'h00);
    step();
    rst_n = 1'b1;
    tick_delay = 0;
    repeat (30) step();
    check("post_rst_pulses", 32'(send_pulses - p0),    32'd0);
    check("post_rst_out",    32'(out_q.size() - out_base), 32'd0);
    check("post_rst_empty",  32'(empty),               32'd1);
    push_byte(8'h3C, 1'b1);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
